// File: rtl/vend_txn_controller.sv
// vend_txn_controller: vending transaction sequencer.
// Latches a price from the one-hot product switches, accumulates coin credit,
// strobes dispense once credit covers the price, then pays change greedily
// (10/5/2/1) as coin-return pulses spaced CHANGE_GAP cycles apart.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sel[3:0]            product switches (valid when exactly one bit set)
//   coin2/coin5/coin10  one-cycle coin pulses; cancel: one-cycle refund request
//   credit[5:0]         current credit in dollars
//   price[4:0]          latched price in dollars
//   dispense            one-cycle vend strobe
//   coin_reject         one-cycle pulse, inserted coin returned
//   change_pulse        one-cycle pulse per change coin; change_val[3:0] = its value
//   state[2:0]          IDLE=0 COLLECT=1 VEND=2 CHANGE=3 DONE=4
module vend_txn_controller #(
  parameter int unsigned PRICE0         = 8,
  parameter int unsigned PRICE1         = 10,
  parameter int unsigned PRICE2         = 12,
  parameter int unsigned PRICE3         = 15,
  parameter int unsigned CREDIT_MAX     = 31,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CHANGE_GAP     = 8,
  parameter int unsigned HOLD_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel,
  input  logic       coin2,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       cancel,
  output logic [5:0] credit,
  output logic [4:0] price,
  output logic       dispense,
  output logic       coin_reject,
  output logic       change_pulse,
  output logic [3:0] change_val,
  output logic [2:0] state
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W  = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            st;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [5:0]        change_amt;

  logic       sel_valid;
  logic [4:0] sel_price;
  logic [1:0] coin_cnt;
  logic       coin_any;
  logic [5:0] coin_value;
  logic [6:0] credit_sum;
  logic       coin_ok;
  logic [5:0] vend_change;
  logic [5:0] chg_src;
  logic [3:0] first_coin;
  logic [3:0] next_coin;

  // Largest coin in {10,5,2,1} not exceeding amt; 0 for amt==0.
  function automatic logic [3:0] largest_coin(input logic [5:0] amt);
    logic [3:0] c;
    if (amt >= 6'd10)     c = 4'd10;
    else if (amt >= 6'd5) c = 4'd5;
    else if (amt >= 6'd2) c = 4'd2;
    else if (amt >= 6'd1) c = 4'd1;
    else                  c = 4'd0;
    return c;
  endfunction

  assign sel_valid = $onehot(sel);
  assign coin_cnt  = 2'(coin2) + 2'(coin5) + 2'(coin10);
  assign coin_any  = (coin_cnt != 2'd0);

  always_comb begin
    sel_price = 5'd0;
    case (sel)
      4'b0001: sel_price = 5'(PRICE0);
      4'b0010: sel_price = 5'(PRICE1);
      4'b0100: sel_price = 5'(PRICE2);
      4'b1000: sel_price = 5'(PRICE3);
      default: sel_price = 5'd0;
    endcase
  end

  always_comb begin
    coin_value = 6'd0;
    if (coin2)       coin_value = 6'd2;
    else if (coin5)  coin_value = 6'd5;
    else if (coin10) coin_value = 6'd10;
  end

  // Single coin that keeps credit within CREDIT_MAX; simultaneous coins are all refused.
  assign credit_sum  = 7'(credit) + 7'(coin_value);
  assign coin_ok     = (coin_cnt == 2'd1) && (credit_sum <= 7'(CREDIT_MAX));
  assign vend_change = credit - {1'b0, price};

  // Amount owed on entry to CHANGE: vend remainder or full refund.
  assign chg_src    = (st == S_VEND) ? vend_change : credit;
  assign first_coin = largest_coin(chg_src);
  assign next_coin  = largest_coin(change_amt);

  assign state = 3'(st);

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      credit       <= 6'd0;
      price        <= 5'd0;
      dispense     <= 1'b0;
      coin_reject  <= 1'b0;
      change_pulse <= 1'b0;
      change_val   <= 4'd0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
      hold_cnt     <= '0;
      change_amt   <= 6'd0;
    end else begin
      dispense     <= 1'b0;
      coin_reject  <= 1'b0;
      change_pulse <= 1'b0;
      change_val   <= 4'd0;
      case (st)
        S_IDLE: begin
          coin_reject <= coin_any;
          if (sel_valid) begin
            price   <= sel_price;
            tmo_cnt <= '0;
            st      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (cancel) begin
            // Refund: first change coin goes out on the first CHANGE cycle.
            coin_reject  <= coin_any;
            credit       <= 6'd0;
            change_amt   <= chg_src - 6'(first_coin);
            change_pulse <= (chg_src != 6'd0);
            change_val   <= first_coin;
            gap_cnt      <= GAP_W'(CHANGE_GAP - 1);
            st           <= S_CHANGE;
          end else if (credit >= {1'b0, price}) begin
            // Committed to vend; coins this cycle are returned.
            coin_reject <= coin_any;
            dispense    <= 1'b1;
            st          <= S_VEND;
          end else if (credit == 6'd0 && !sel_valid) begin
            coin_reject <= coin_any;
            price       <= 5'd0;
            st          <= S_IDLE;
          end else if (coin_ok) begin
            credit  <= credit_sum[5:0];
            tmo_cnt <= '0;
          end else begin
            coin_reject <= coin_any;
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
              // Counter holds at the limit while no credit is owed.
              if (credit != 6'd0) begin
                credit       <= 6'd0;
                change_amt   <= chg_src - 6'(first_coin);
                change_pulse <= 1'b1;
                change_val   <= first_coin;
                gap_cnt      <= GAP_W'(CHANGE_GAP - 1);
                st           <= S_CHANGE;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        S_VEND: begin
          coin_reject  <= coin_any;
          credit       <= 6'd0;
          change_amt   <= chg_src - 6'(first_coin);
          change_pulse <= (chg_src != 6'd0);
          change_val   <= first_coin;
          gap_cnt      <= GAP_W'(CHANGE_GAP - 1);
          st           <= S_CHANGE;
        end
        S_CHANGE: begin
          coin_reject <= coin_any;
          if (change_amt == 6'd0) begin
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            st       <= S_DONE;
          end else if (gap_cnt == '0) begin
            change_pulse <= 1'b1;
            change_val   <= next_coin;
            change_amt   <= change_amt - 6'(next_coin);
            gap_cnt      <= GAP_W'(CHANGE_GAP - 1);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          coin_reject <= coin_any;
          if (hold_cnt == '0) begin
            price <= 5'd0;
            st    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
- Transaction sequencer for the vending machine datapath.
- Latches the product price from the one-hot switch selection and accumulates credit from debounced coin pulses ($2/$5/$10).
- Fires a one-cycle dispense strobe when credit covers the price, then pays change greedily as timed coin-return pulses.
- Sits between the button/switch conditioning logic and the 7-segment/LED display driver.

Parameters:
PRICE0, 8, price in dollars for sel[0]
PRICE1, 10, price for sel[1]
PRICE2, 12, price for sel[2]
PRICE3, 15, price for sel[3]
CREDIT_MAX, 31, maximum credit accepted (dollars)
TIMEOUT_CYCLES, 1000, COLLECT idle cycles before auto-refund
CHANGE_GAP, 8, cycles between change coin pulses
HOLD_CYCLES, 16, cycles the DONE status is held before returning to IDLE

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sel  in  4  product switches; valid only when exactly one bit is set
coin2  in  1  one-cycle pulse, $2 inserted
coin5  in  1  one-cycle pulse, $5 inserted
coin10  in  1  one-cycle pulse, $10 inserted
cancel  in  1  one-cycle pulse, refund request
credit  out  6  current credit, binary dollars
price  out  5  latched price, binary dollars
dispense  out  1  one-cycle vend strobe
coin_reject  out  1  one-cycle pulse, inserted coin returned unaccepted
change_pulse  out  1  one-cycle pulse, one change coin paid
change_val  out  4  denomination of the current change coin (10/5/2/1); 0 when change_pulse is low
state  out  3  encoded state, for LEDs: IDLE=0 COLLECT=1 VEND=2 CHANGE=3 DONE=4

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; credit=0, price=0, change register=0; all pulse outputs 0; timers cleared. Reset mid-transaction discards credit with no refund pulses.
- sel_valid = exactly one bit of sel set. Zero or multiple bits set = invalid.
- IDLE:
  - Coin pulse -> coin_reject next cycle; credit unchanged.
  - sel_valid -> COLLECT next cycle; price latched from the PRICEn table; timeout counter cleared.
- COLLECT:
  - Exactly one coin pulse with credit+value <= CREDIT_MAX: credit += value, registered 1 cycle after the pulse; timeout counter cleared.
  - Coin that would exceed CREDIT_MAX: coin_reject, credit unchanged.
  - Two or more coin pulses in the same cycle: coin_reject (single pulse), none accepted.
  - price stays latched; sel changes are ignored while credit>0.
  - If credit==0 and sel becomes invalid -> IDLE, price cleared.
  - Refund: cancel, or timeout counter reaching TIMEOUT_CYCLES with credit>0 -> CHANGE with change=credit, credit=0.
  - Timeout with credit==0 -> stay in COLLECT, counter held.
  - Priority in one cycle: cancel > coin. A coin arriving with cancel is rejected.
  - When credit >= price (evaluated on the registered credit) -> VEND.
- VEND (exactly 1 cycle): dispense=1; change = credit - price; credit=0; next state CHANGE.
- CHANGE:
  - Each CHANGE_GAP cycles, while change>0, emit one change_pulse.
  - change_val is the largest coin in {10,5,2,1} not exceeding change; change -= change_val.
  - The first pulse is issued on the first cycle in CHANGE.
  - When change==0 -> DONE. Zero change means CHANGE lasts 1 cycle with no pulse.
- DONE: hold HOLD_CYCLES, then IDLE. price cleared on entry to IDLE.
- Coin pulses in VEND/CHANGE/DONE -> coin_reject; cancel is ignored.
- Arithmetic: credit 6-bit unsigned, never exceeds CREDIT_MAX; change is 6-bit; no wrap possible.
- All outputs registered. dispense, change_pulse and coin_reject are never high for more than 1 consecutive cycle, except coin_reject on back-to-back rejected coins.

Test Plan:
- sel=0100, coin2, coin5, coin10 spaced 20 cycles -> price=12; credit 2,7,17; dispense once; one change_pulse val=5; DONE; IDLE.
- sel=0001, coin10 -> price=8; dispense 1 cycle after credit=10; change_pulse val=2; credit 0.
- sel=1000, coin5, cancel -> no dispense; change_pulse val=5; state DONE then IDLE.
- sel=1000 with parameter override CREDIT_MAX=12, coin10 then coin5 -> coin5 rejected (15>12), credit=10; then coin5 with default CREDIT_MAX -> vend, change 0, no change_pulse.
- coin5 and coin2 in the same cycle in COLLECT -> single coin_reject, credit unchanged. coin2 in IDLE -> coin_reject.
- Timeout: sel=0010, coin2, no activity for 1000 cycles -> change_pulse val=2, no dispense. rst asserted mid-COLLECT with credit=7 -> next cycle state=IDLE, credit=0, no change pulses.
